axi_sram_slave: RTL
===================

Name: axi_sram_slave

Overview:
AXI-style responder that fronts one single-port synchronous SRAM bank (IM or DM) behind the interconnect. It is the slave-side counterpart of the CPU wrapper masters. It accepts single-beat writes and INCR/FIXED bursts of up to 16 beats on both read and write. It converts each beat into SRAM chip-enable, byte-write-enable, address and data strobes.

Parameters:
ADDR_W, 14, SRAM word-address width; the SRAM address is AxADDR[ADDR_W+1:2].
ID_W, 8, slave-side transaction ID width (master ID concatenated by the interconnect).

Ports:
ACLK  in  1  clock
ARESETn  in  1  reset
AWID_S/AWADDR_S/AWLEN_S/AWSIZE_S/AWBURST_S  in  ID_W/32/4/3/2  write address
AWVALID_S  in  1; AWREADY_S  out  1
WDATA_S/WSTRB_S/WLAST_S  in  32/4/1  write data
WVALID_S  in  1; WREADY_S  out  1
BID_S  out  ID_W; BRESP_S  out  2; BVALID_S  out  1; BREADY_S  in  1
ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  in  ID_W/32/4/3/2  read address
ARVALID_S  in  1; ARREADY_S  out  1
RID_S  out  ID_W; RDATA_S  out  32; RRESP_S  out  2; RLAST_S  out  1; RVALID_S  out  1; RREADY_S  in  1
CEB  out  1  SRAM chip enable, active-low
WEB  out  4  SRAM per-byte write enable, active-low
A  out  ADDR_W  SRAM word address
DI  out  32  SRAM write data
DO  in  32  SRAM read data; valid 1 cycle after CEB=0/WEB=4'hF; holds while CEB=1

Behaviour:
- Reset is ARESETn, synchronous, active-low; the clock is ACLK.
- Reset values: all READY/VALID outputs 0; RLAST_S 0; BRESP_S/RRESP_S 2'b00; IDs 0; CEB 1; WEB 4'hF; A 0; DI 0. State goes to IDLE, and counters and captured registers clear.
- Reset mid-burst aborts the transaction and no response is issued.
- FSM states: IDLE, R_FETCH, R_DATA, W_DATA, W_RESP. Only one transaction is in flight; there is no outstanding queue.
- IDLE:
  - AWREADY_S=1.
  - ARREADY_S = ~AWVALID_S, so a write wins a simultaneous request.
  - On an AW handshake: capture AWID, AWADDR word, AWLEN, AWBURST; beat count = 0; go to W_DATA.
  - On an AR handshake: capture the same fields from AR; go to R_FETCH.
- R_FETCH (1 cycle): CEB=0, WEB=4'hF, A=current word address; go to R_DATA.
- R_DATA:
  - RVALID_S=1, RDATA_S=DO, RID_S=captured ID, RRESP_S=00.
  - RLAST_S=1 when beat count == captured LEN.
  - CEB=1, so DO stays stable while RREADY_S=0; RDATA_S must not change until the handshake.
  - On RVALID&RREADY: if last, go to IDLE; otherwise beat count +1, address update, go to R_FETCH.
  - Read throughput is 1 beat per 2 cycles minimum.
- W_DATA:
  - WREADY_S=1.
  - On WVALID_S: same cycle CEB=0, WEB=~WSTRB_S, DI=WDATA_S, A=current word address; beat count +1; address update.
  - If WLAST_S or beat count == LEN: go to W_RESP.
  - Error flag is set if WLAST_S arrives early, or is missing at beat LEN.
  - WSTRB_S=4'h0 gives WEB=4'hF (no-op write cycle; still counts as a beat).
- W_RESP:
  - BVALID_S=1, BID_S=captured ID, BRESP_S = error flag ? 2'b10 (SLVERR) : 2'b00.
  - Held until BREADY_S; then go to IDLE, clearing the error flag.
- Address update:
  - INCR (01) and WRAP (10, treated as INCR): word address +1, wrapping modulo 2^ADDR_W.
  - FIXED (00): unchanged.
  - Reserved (11) behaves as INCR.
- AxSIZE is ignored; all beats are 32-bit. Upper address bits above ADDR_W+1 are ignored (the interconnect decodes them).
- Outside the access states: CEB=1 and WEB=4'hF. DI and A may hold their last value.

Test Plan:
- Reset: hold ARESETn=0 for 3 cycles while AWVALID=1 -> AWREADY/ARREADY/BVALID/RVALID stay 0, CEB=1, WEB=F. After release, IDLE shows AWREADY=1.
- Single write: AWADDR=0x0000_0010, AWLEN=0, AWID=0x12; W: WDATA=0xDEADBEEF, WSTRB=4'b0011, WLAST=1 -> A=4, WEB=4'b1100, DI=0xDEADBEEF for one cycle. Then BVALID=1, BID=0x12, BRESP=00 until BREADY.
- Burst read: SRAM preloaded words 4..8 = 1..5; ARADDR=0x10, ARLEN=4, ARID=0x21 -> 5 R beats with RDATA 1,2,3,4,5 and RID=0x21. RLAST only on beat 5. Random RREADY stalls leave RDATA unchanged.
- Simultaneous AWVALID and ARVALID in IDLE -> the AW handshake occurs first and ARREADY=0 that cycle. The AR is accepted in the first IDLE cycle after BVALID&BREADY.
- WLAST mismatch: AWLEN=2 with WLAST on beat 1 -> exactly 1 SRAM write, BRESP=2'b10. The next clean write returns BRESP=00.
- Wrap-around and FIXED: INCR read at word 2^ADDR_W-1 with LEN=1 -> second beat at A=0. FIXED write LEN=3 -> all 4 beats at the same A, final data = beat 4.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI-style slave that maps single beats and INCR/FIXED bursts (up to 16 beats)
// onto one single-port synchronous SRAM bank. One transaction in flight at a time.
module axi_sram_slave #(
  parameter int ADDR_W = 14,
  parameter int ID_W   = 8
) (
  input  logic              ACLK,
  input  logic              ARESETn,
  // write address
  input  logic [ID_W-1:0]   AWID_S,
  input  logic [31:0]       AWADDR_S,
  input  logic [3:0]        AWLEN_S,
  input  logic [2:0]        AWSIZE_S,
  input  logic [1:0]        AWBURST_S,
  input  logic              AWVALID_S,
  output logic              AWREADY_S,
  // write data
  input  logic [31:0]       WDATA_S,
  input  logic [3:0]        WSTRB_S,
  input  logic              WLAST_S,
  input  logic              WVALID_S,
  output logic              WREADY_S,
  // write response
  output logic [ID_W-1:0]   BID_S,
  output logic [1:0]        BRESP_S,
  output logic              BVALID_S,
  input  logic              BREADY_S,
  // read address
  input  logic [ID_W-1:0]   ARID_S,
  input  logic [31:0]       ARADDR_S,
  input  logic [3:0]        ARLEN_S,
  input  logic [2:0]        ARSIZE_S,
  input  logic [1:0]        ARBURST_S,
  input  logic              ARVALID_S,
  output logic              ARREADY_S,
  // read data
  output logic [ID_W-1:0]   RID_S,
  output logic [31:0]       RDATA_S,
  output logic [1:0]        RRESP_S,
  output logic              RLAST_S,
  output logic              RVALID_S,
  input  logic              RREADY_S,
  // SRAM
  output logic              CEB,
  output logic [3:0]        WEB,
  output logic [ADDR_W-1:0] A,
  output logic [31:0]       DI,
  input  logic [31:0]       DO
);

  typedef enum logic [2:0] {IDLE, R_FETCH, R_DATA, W_DATA, W_RESP} state_e;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_e              state_q;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [3:0]          len_q;
  logic [3:0]          cnt_q;
  logic [1:0]          burst_q;
  logic                err_q;
  logic                rvalid_q;
  logic                rlast_q;
  logic                bvalid_q;
  logic [1:0]          bresp_q;

  logic                w_beat;
  logic                w_at_len;
  logic                w_done;
  logic                w_err;

  // Size and out-of-bank address bits are decoded upstream.
  logic unused_bits;
  assign unused_bits = ^{AWSIZE_S, ARSIZE_S, AWADDR_S[31:ADDR_W+2], AWADDR_S[1:0],
                         ARADDR_S[31:ADDR_W+2], ARADDR_S[1:0]};

  // WRAP and the reserved encoding both advance like INCR.
  assign addr_d   = (burst_q == BURST_FIXED) ? addr_q : addr_q + ADDR_W'(1);

  assign w_beat   = (state_q == W_DATA) && WVALID_S;
  assign w_at_len = (cnt_q == len_q);
  assign w_done   = WLAST_S || w_at_len;
  assign w_err    = WLAST_S != w_at_len;

  // NOTE: every register here uses <= so all next-state terms read pre-edge values.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q  <= IDLE;
      id_q     <= '0;
      addr_q   <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      burst_q  <= '0;
      err_q    <= 1'b0;
      rvalid_q <= 1'b0;
      rlast_q  <= 1'b0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      case (state_q)
        IDLE: begin
          if (AWVALID_S) begin
            id_q    <= AWID_S;
            addr_q  <= AWADDR_S[ADDR_W+1:2];
            len_q   <= AWLEN_S;
            burst_q <= AWBURST_S;
            cnt_q   <= '0;
            state_q <= W_DATA;
          end else if (ARVALID_S) begin
            id_q    <= ARID_S;
            addr_q  <= ARADDR_S[ADDR_W+1:2];
            len_q   <= ARLEN_S;
            burst_q <= ARBURST_S;
            cnt_q   <= '0;
            state_q <= R_FETCH;
          end
        end
        R_FETCH: begin
          rvalid_q <= 1'b1;
          rlast_q  <= (cnt_q == len_q);
          state_q  <= R_DATA;
        end
        R_DATA: begin
          if (RREADY_S) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 4'd1;
              addr_q  <= addr_d;
              state_q <= R_FETCH;
            end
          end
        end
        W_DATA: begin
          if (WVALID_S) begin
            cnt_q  <= cnt_q + 4'd1;
            addr_q <= addr_d;
            if (w_err) err_q <= 1'b1;
            if (w_done) begin
              bvalid_q <= 1'b1;
              bresp_q  <= (err_q || w_err) ? RESP_SLVERR : RESP_OKAY;
              state_q  <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (BREADY_S) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
            err_q    <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write strobes must reach the SRAM in the same cycle as the W handshake,
  // so the SRAM-side and ready outputs are decoded from state, gated by reset.
  assign AWREADY_S = ARESETn && (state_q == IDLE);
  assign ARREADY_S = ARESETn && (state_q == IDLE) && !AWVALID_S;
  assign WREADY_S  = ARESETn && (state_q == W_DATA);

  assign CEB = !(ARESETn && ((state_q == R_FETCH) || w_beat));
  assign WEB = (ARESETn && w_beat) ? ~WSTRB_S : 4'hF;
  assign A   = addr_q;
  assign DI  = (ARESETn && w_beat) ? WDATA_S : '0;

  // DO holds while CEB is high, so read data stays stable through RREADY stalls.
  assign RDATA_S  = (state_q == R_DATA) ? DO : '0;
  assign RVALID_S = rvalid_q;
  assign RLAST_S  = rlast_q;
  assign RID_S    = id_q;
  assign RRESP_S  = RESP_OKAY;

  assign BVALID_S = bvalid_q;
  assign BID_S    = id_q;
  assign BRESP_S  = bresp_q;

endmodule
